darkfetch_queue: RTL and testbench

Instruction fetch front-end that drives the instruction ROM over the darkbus and buffers returned words, with their PCs, in a small FIFO for the decode stage. It generates sequential fetch addresses, tracks the single in-flight ROM request (fixed 1-cycle latency), applies credit-based flow control so no response is ever dropped, and flushes and restarts on a branch or jump redirect.

---
 rtl/darkfetch_queue_if.sv | 28 ++
 rtl/darkfetch_queue.sv | 123 ++++++++++++
 tb/tb_darkfetch_queue.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/darkfetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : darkfetch_queue_if
//  Description : darkbus request/response bundle between the fetch front-end
//                (master) and the instruction ROM (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface darkfetch_queue_if;
    logic [31:0] addr;
    logic        en;
    logic [31:0] data;
    logic        valid;

    modport master (
        output addr,
        output en,
        input  data,
        input  valid
    );

    modport slave (
        input  addr,
        input  en,
        output data,
        output valid
    );
endinterface
`default_nettype wire

// File: rtl/darkfetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : darkfetch_queue
//  Description : Instruction fetch front-end. Issues sequential ROM reads over
//                the darkbus (fixed 1-cycle latency), buffers returned words
//                with their PCs in a DEPTH-entry FIFO and flushes/restarts on
//                a redirect. Credit flow control guarantees no dropped word.
//  Revision    : 1.0 - initial release
// ============================================================================
module darkfetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  wire logic              XCLK,
    input  wire logic              XRES,
    darkfetch_queue_if.master      BUS,
    input  wire logic              REDIR,
    input  wire logic [31:0]       REDIR_PC,
    output logic                   IVALID,
    input  wire logic              IREADY,
    output logic [31:0]            IDATA,
    output logic [31:0]            IPC
);

    localparam int              c_AW       = $clog2(DEPTH);
    localparam int              c_CW       = c_AW + 1;
    localparam logic [c_CW:0]   c_DEPTH_W  = (c_CW + 1)'(DEPTH);
    localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    // Fetch sequencing state
    logic [31:0]     r_pc;
    logic            r_infl;
    logic [31:0]     r_infl_pc;

    // FIFO state; storage is deliberately left without reset
    logic [31:0]     r_mem_pc   [DEPTH];
    logic [31:0]     r_mem_data [DEPTH];
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_CW-1:0] r_count;

    logic [c_CW:0]   w_credits_used;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    logic [31:0]     w_redir_target;
    logic            w_unused;

    // Credits: every buffered word plus the one in flight must fit the FIFO.
    // Reset gates the request so the bus stays quiet while XRES is held.
    always_comb begin
        w_credits_used = {1'b0, r_count} + {{c_CW{1'b0}}, r_infl};
        w_issue        = !XRES && !REDIR && (w_credits_used < c_DEPTH_W);
        w_push         = r_infl && BUS.valid && !REDIR;
        w_pop          = (r_count != '0) && IREADY;
        w_redir_target = {REDIR_PC[31:2], 2'b00};
    end

    assign w_unused = ^REDIR_PC[1:0];

    assign BUS.en   = w_issue;
    assign BUS.addr = r_pc;

    // Output head entry, masked to zero while the FIFO is empty
    always_comb begin
        IVALID = (r_count != '0);
        IDATA  = IVALID ? r_mem_data[r_rd_ptr] : 32'h0;
        IPC    = IVALID ? r_mem_pc[r_rd_ptr]   : 32'h0;
    end

    // Fetch address generation and in-flight request tracking
    always_ff @(posedge XCLK or posedge XRES) begin
        if (XRES) begin
            r_pc      <= RESET_PC;
            r_infl    <= 1'b0;
            r_infl_pc <= 32'h0;
        end else begin
            r_infl <= w_issue;
            if (REDIR) begin
                r_pc <= w_redir_target;
            end else if (w_issue) begin
                r_pc      <= r_pc + 32'd4;
                r_infl_pc <= r_pc;
            end
        end
    end

    // FIFO pointers and occupancy; a redirect flush overrides push and pop
    always_ff @(posedge XCLK or posedge XRES) begin
        if (XRES) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (REDIR) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage write: returned word tagged with the address it came from
    always_ff @(posedge XCLK) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= r_infl_pc;
            r_mem_data[r_wr_ptr] <= BUS.data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_darkfetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_darkfetch_queue
//  Description : Self-checking bench for darkfetch_queue: ROM slave model,
//                queue-based reference of the fetch buffer, directed scenarios
//                and a randomized run with redirects.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_darkfetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        XCLK     = 1'b0;
    logic        XRES     = 1'b1;
    logic        REDIR    = 1'b0;
    logic [31:0] REDIR_PC = 32'h0;
    logic        IREADY   = 1'b0;
    logic        IVALID;
    logic [31:0] IDATA;
    logic [31:0] IPC;

    darkfetch_queue_if bus ();

    darkfetch_queue #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .XCLK     (XCLK),
        .XRES     (XRES),
        .BUS      (bus),
        .REDIR    (REDIR),
        .REDIR_PC (REDIR_PC),
        .IVALID   (IVALID),
        .IREADY   (IREADY),
        .IDATA    (IDATA),
        .IPC      (IPC)
    );

    always #5 XCLK = ~XCLK;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    // Reference: buffered words in program order, next fetch PC, in-flight PC
    entry_t      mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_infl_pc;
    bit          m_infl;

    // ROM slave bookkeeping and per-cycle observations
    bit          prev_en;
    logic [31:0] prev_addr;
    bit          spurious;
    bit          obs_en;
    bit          obs_ivalid;
    logic [31:0] obs_addr;
    logic [31:0] obs_ipc;
    logic [31:0] obs_idata;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc      = RESET_PC;
        m_infl    = 1'b0;
        m_infl_pc = 32'h0;
        prev_en   = 1'b0;
        prev_addr = 32'h0;
    endtask

    // One clock cycle: called just after a falling edge, returns at the next.
    task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy);
        bit     e_en;
        bit     e_val;
        entry_t h;
        entry_t n;
        REDIR    = redir;
        REDIR_PC = rpc;
        IREADY   = rdy;
        if (prev_en) begin
            bus.valid = 1'b1;
            bus.data  = rom(prev_addr);
        end else begin
            bus.valid = spurious && ($urandom_range(0, 3) == 0);
            bus.data  = $urandom;
        end
        #1;
        e_en  = !redir && ((mq.size() + int'(m_infl)) < DEPTH);
        e_val = (mq.size() != 0);
        h     = e_val ? mq[0] : '0;
        check("bus_en", 32'(bus.en), 32'(e_en));
        if (e_en) check("bus_addr", bus.addr, m_pc);
        check("ivalid", 32'(IVALID), 32'(e_val));
        check("ipc", IPC, h.pc);
        check("idata", IDATA, h.data);
        check("count", 32'(dut.r_count), 32'(mq.size()));
        if (IVALID && rdy) check("rom_word", IDATA, rom(IPC));
        obs_en     = bus.en;
        obs_addr   = bus.addr;
        obs_ivalid = IVALID;
        obs_ipc    = IPC;
        obs_idata  = IDATA;
        if (e_val && rdy) void'(mq.pop_front());
        if (redir) begin
            mq.delete();
            m_pc   = {rpc[31:2], 2'b00};
            m_infl = 1'b0;
        end else begin
            if (m_infl && bus.valid) begin
                n.pc   = m_infl_pc;
                n.data = bus.data;
                mq.push_back(n);
            end
            if (e_en) begin
                m_infl_pc = m_pc;
                m_pc      = m_pc + 32'd4;
            end
            m_infl = e_en;
        end
        prev_en   = bus.en;
        prev_addr = bus.addr;
        @(negedge XCLK);
    endtask

    task automatic do_reset();
        XRES      = 1'b1;
        REDIR     = 1'b0;
        IREADY    = 1'b0;
        bus.valid = 1'b0;
        bus.data  = 32'h0;
        @(negedge XCLK);
        @(negedge XCLK);
        check("rst_en", 32'(bus.en), 32'h0);
        check("rst_ivalid", 32'(IVALID), 32'h0);
        check("rst_ipc", IPC, 32'h0);
        check("rst_idata", IDATA, 32'h0);
        model_reset();
        XRES = 1'b0;
    endtask

    initial begin
        int  en_cnt;
        bit  last_redir;
        bit  r;
        logic [31:0] t;

        spurious = 1'b0;

        // Streaming after reset: first word at cycle 2, then one per cycle
        do_reset();
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 32'h0, 1'b1);
            if (k == 0) check("first_addr", obs_addr, RESET_PC);
            if (k >= 2) begin
                check("stream_valid", 32'(obs_ivalid), 32'h1);
                check("stream_ipc", obs_ipc, 32'(4 * (k - 2)));
            end
            if (k == 2) check("stream_idata0", obs_idata, 32'h0);
        end

        // Backpressure: exactly DEPTH requests, then drain in order
        do_reset();
        en_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 32'h0, 1'b0);
            if (obs_en) begin
                if (en_cnt < DEPTH) check("fill_addr", obs_addr, 32'(4 * en_cnt));
                en_cnt++;
            end
        end
        check("fill_issues", 32'(en_cnt), 32'(DEPTH));
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 32'h0, 1'b1);
            check("drain_valid", 32'(obs_ivalid), 32'h1);
            check("drain_ipc", obs_ipc, 32'(4 * k));
            if (k == 0) check("drain_hold_en", 32'(obs_en), 32'h0);
            if (k == 1) check("resume_addr", obs_addr, 32'h10);
        end

        // Redirect with three buffered words and one in flight
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h103, 1'b0);
        check("redir_en", 32'(obs_en), 32'h0);
        step(1'b0, 32'h0, 1'b0);
        check("redir_flush", 32'(obs_ivalid), 32'h0);
        check("redir_addr", obs_addr, 32'h100);
        step(1'b0, 32'h0, 1'b0);
        check("redir_wait", 32'(obs_ivalid), 32'h0);
        step(1'b0, 32'h0, 1'b1);
        check("redir_valid", 32'(obs_ivalid), 32'h1);
        check("redir_ipc", obs_ipc, 32'h100);
        check("redir_idata", obs_idata, 32'h40);

        // Back-to-back redirects: the later target wins
        step(1'b1, 32'h40, 1'b1);
        step(1'b1, 32'h80, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        check("b2b_addr", obs_addr, 32'h80);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        check("b2b_ipc", obs_ipc, 32'h80);

        // Randomized traffic with redirects, spurious valids and PC wrap
        spurious   = 1'b1;
        last_redir = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            r = ($urandom_range(0, 29) == 0) || (last_redir && ($urandom_range(0, 2) == 0));
            t = $urandom;
            if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFE0 | (t & 32'h1F);
            step(r, t, 1'($urandom_range(0, 1)));
            last_redir = r;
        end

        // Asynchronous reset mid-stream
        spurious = 1'b0;
        do_reset();
        for (int k = 0; k < 6; k++) step(1'b0, 32'h0, 1'b1);
        IREADY    = 1'b1;
        bus.valid = prev_en;
        bus.data  = rom(prev_addr);
        #1;
        check("pre_arst_en", 32'(bus.en), 32'h1);
        check("pre_arst_ivalid", 32'(IVALID), 32'h1);
        #2;
        XRES = 1'b1;
        #1;
        check("arst_en", 32'(bus.en), 32'h0);
        check("arst_ivalid", 32'(IVALID), 32'h0);
        check("arst_ipc", IPC, 32'h0);
        @(negedge XCLK);
        @(negedge XCLK);
        model_reset();
        bus.valid = 1'b0;
        XRES      = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 32'h0, 1'b1);
            if (k == 0) check("arst_restart_addr", obs_addr, RESET_PC);
            if (k == 2) check("arst_restart_ipc", obs_ipc, RESET_PC);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
